// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared state type and constants for the instruction fetch unit
package ifu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_INC           = 32'd4;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular fetch buffer with push, pop and flush
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != FULL);

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, single-outstanding fetch FSM and decode buffer
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              out_mem_req_valid,
    output logic [ADDR_W-1:0] out_mem_req_addr,
    input  logic              in_mem_req_ready,
    input  logic              in_mem_resp_valid,
    input  logic [INST_W-1:0] in_mem_resp_data,
    input  logic              in_redirect_valid,
    input  logic [ADDR_W-1:0] in_redirect_pc,
    output logic              out_inst_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_inst_pc,
    input  logic              in_inst_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       out_fetch_count,
    output logic [31:0]       out_stall_count
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    ifu_state_t               state;
    logic [ADDR_W-1:0]        pc;
    logic [ADDR_W-1:0]        req_pc;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_after_push;
    logic [ADDR_W+INST_W-1:0] head;
    logic                     req_hs;
    logic                     push;
    logic                     pop;

    assign req_hs           = (state == REQ) && in_mem_req_ready;
    assign pop              = (count != '0) && in_inst_ready;
    assign push             = (state == WAIT) && in_mem_resp_valid && !in_redirect_valid;
    assign count_after_push = count + CNT_W'(1) - CNT_W'(pop);

    // Redirect wins over every other transition; a request accepted or still
    // in flight at redirect time is answered later and must be swallowed in DROP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            case (state)
                IDLE: if (in_redirect_valid || count < FULL) state <= REQ;
                REQ: begin
                    if (req_hs) begin
                        req_pc <= pc;
                        state  <= in_redirect_valid ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (in_mem_resp_valid)
                        state <= (in_redirect_valid || count_after_push < FULL) ? REQ : IDLE;
                    else if (in_redirect_valid)
                        state <= DROP;
                end
                DROP: if (in_mem_resp_valid) state <= REQ;
                default: state <= IDLE;
            endcase

            if (in_redirect_valid)
                pc <= {in_redirect_pc[ADDR_W-1:2], 2'b00};
            else if (req_hs)
                pc <= pc + PC_INC;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({req_pc, in_mem_resp_data}),
        .pop       (pop),
        .flush     (in_redirect_valid),
        .head_data (head),
        .count     (count)
    );

    assign out_mem_req_valid = (state == REQ);
    assign out_mem_req_addr  = (state == REQ) ? pc : '0;
    assign out_inst_valid    = (count != '0);
    assign out_inst_pc       = out_inst_valid ? head[ADDR_W+INST_W-1:INST_W] : '0;
    assign out_inst          = out_inst_valid ? head[INST_W-1:0] : '0;

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_fetch_count <= '0;
            out_stall_count <= '0;
        end else begin
            if (pop) out_fetch_count <= out_fetch_count + 32'd1;
            if (in_inst_ready && count == '0) out_stall_count <= out_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized bench with transaction-level fetch model
module tb_instruction_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        out_mem_req_valid;
    logic [31:0] out_mem_req_addr;
    logic        in_mem_req_ready = 1'b0;
    logic        in_mem_resp_valid = 1'b0;
    logic [31:0] in_mem_resp_data = '0;
    logic        in_redirect_valid = 1'b0;
    logic [31:0] in_redirect_pc = '0;
    logic        out_inst_valid;
    logic [31:0] out_inst;
    logic [31:0] out_inst_pc;
    logic        in_inst_ready = 1'b0;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .out_mem_req_valid (out_mem_req_valid),
        .out_mem_req_addr  (out_mem_req_addr),
        .in_mem_req_ready  (in_mem_req_ready),
        .in_mem_resp_valid (in_mem_resp_valid),
        .in_mem_resp_data  (in_mem_resp_data),
        .in_redirect_valid (in_redirect_valid),
        .in_redirect_pc    (in_redirect_pc),
        .out_inst_valid    (out_inst_valid),
        .out_inst          (out_inst),
        .out_inst_pc       (out_inst_pc),
        .in_inst_ready     (in_inst_ready)
`ifdef IFU_PERF_CNT_EN
        ,
        .out_fetch_count   (fetch_count),
        .out_stall_count   (stall_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Model: buffered PCs (words derive from PC), next fetch PC, memory slot
    logic [31:0] q_pc[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] fetch_exp;
    bit          mem_busy;
    bit          drop_pend;
    logic [31:0] mem_addr;
    int          mem_wait;
    int          idle_cycles;
    logic [31:0] fetch_cnt_m;
    logic [31:0] stall_cnt_m;

    int          p_ready, p_iready, p_redir, lat_max;
    bit          force_redir;
    logic [31:0] force_pc;

    bit          s_req_valid;
    logic [31:0] s_addr;
    bit          prev_stall;
    logic [31:0] prev_addr;
    bit          prev_redir_req;
    logic [31:0] prev_target;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] log_at(input logic [31:0] lg[$], input int i);
        return (lg.size() > i) ? lg[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        fetch_exp      = 32'h0;
        mem_busy       = 0;
        drop_pend      = 0;
        mem_wait       = 0;
        idle_cycles    = 0;
        fetch_cnt_m    = 0;
        stall_cnt_m    = 0;
        prev_stall     = 0;
        prev_redir_req = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_mem_req_ready = 0; in_mem_resp_valid = 0; in_mem_resp_data = '0;
        in_redirect_valid = 0; in_redirect_pc = '0; in_inst_ready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_valid", out_mem_req_valid, 0);
            chk("rst_req_addr", out_mem_req_addr, 0);
            chk("rst_inst_valid", out_inst_valid, 0);
            chk("rst_inst", out_inst, 0);
            chk("rst_inst_pc", out_inst_pc, 0);
`ifdef IFU_PERF_CNT_EN
            chk("rst_fetch_count", fetch_count, 0);
            chk("rst_stall_count", stall_count, 0);
`endif
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic compare();
        chk("inst_valid", out_inst_valid, q_pc.size() != 0);
        if (q_pc.size() != 0) begin
            chk("inst_pc", out_inst_pc, q_pc[0]);
            chk("inst", out_inst, word_of(q_pc[0]));
        end
        if (out_mem_req_valid) begin
            chk("req_room", q_pc.size() < DEPTH, 1);
            chk("req_single", mem_busy, 0);
        end
        if (prev_stall) begin
            chk("req_hold_valid", out_mem_req_valid, 1);
            chk("req_hold_addr", out_mem_req_addr, prev_addr);
        end
        if (prev_redir_req) begin
            chk("redir_req_valid", out_mem_req_valid, 1);
            chk("redir_req_addr", out_mem_req_addr, prev_target);
        end
        chk("progress", idle_cycles < 40, 1);
        if (idle_cycles >= 40) idle_cycles = 0;
`ifdef IFU_PERF_CNT_EN
        chk("fetch_count", fetch_count, fetch_cnt_m);
        chk("stall_count", stall_count, stall_cnt_m);
`endif
        s_req_valid = out_mem_req_valid;
        s_addr      = out_mem_req_addr;
    endtask

    task automatic drive();
        logic [31:0] t;
        in_inst_ready    = ($urandom_range(0, 99) < p_iready);
        in_mem_req_ready = ($urandom_range(0, 99) < p_ready);
        in_mem_resp_valid = mem_busy && (mem_wait == 1);
        in_mem_resp_data  = in_mem_resp_valid ? word_of(mem_addr) : $urandom;
        case ($urandom_range(0, 2))
            0:       t = $urandom;
            1:       t = $urandom_range(0, 255);
            default: t = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        endcase
        in_redirect_valid = force_redir || ($urandom_range(0, 99) < p_redir);
        in_redirect_pc    = force_redir ? force_pc : t;
    endtask

    task automatic update();
        bit popped;
        bit accepted;
        popped   = (q_pc.size() != 0) && in_inst_ready;
        accepted = s_req_valid && in_mem_req_ready;
        if (popped) fetch_cnt_m++;
        if (in_inst_ready && q_pc.size() == 0) stall_cnt_m++;
        if (popped) begin
            pop_log.push_back(q_pc[0]);
            void'(q_pc.pop_front());
        end
        if (in_mem_resp_valid) begin
            if (!in_redirect_valid && !drop_pend) q_pc.push_back(mem_addr);
            drop_pend = 0;
            mem_busy  = 0;
        end else if (mem_busy) begin
            mem_wait--;
        end
        if (accepted) begin
            chk("req_addr", s_addr, fetch_exp);
            acc_log.push_back(s_addr);
            fetch_exp = fetch_exp + 32'd4;
            mem_busy  = 1;
            mem_addr  = s_addr;
            mem_wait  = $urandom_range(1, lat_max);
        end
        prev_stall     = s_req_valid && !in_mem_req_ready && !in_redirect_valid;
        prev_addr      = s_addr;
        prev_redir_req = in_redirect_valid && !mem_busy;
        if (in_redirect_valid) begin
            q_pc.delete();
            fetch_exp   = in_redirect_pc & ~32'd3;
            prev_target = fetch_exp;
            if (mem_busy) drop_pend = 1;
        end
        idle_cycles = (accepted || popped) ? 0 : idle_cycles + 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            compare();
            drive();
            @(posedge clk);
            #1;
            update();
            @(negedge clk);
        end
    endtask

    task automatic set_knobs(input int r, input int ir, input int rd, input int lat);
        p_ready = r; p_iready = ir; p_redir = rd; lat_max = lat;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        pop_log.delete();
    endtask

    task automatic redirect_once(input logic [31:0] t);
        force_redir = 1; force_pc = t;
        run(1);
        force_redir = 0;
    endtask

    initial begin
        int guard;
        force_redir = 0;
        set_knobs(100, 100, 0, 1);
        model_reset();

        // Streaming fetch from reset
        do_reset();
        clear_logs();
        run(14);
        chk("a_acc0", log_at(acc_log, 0), 32'h0);
        chk("a_acc1", log_at(acc_log, 1), 32'h4);
        chk("a_acc2", log_at(acc_log, 2), 32'h8);
        chk("a_pop0", log_at(pop_log, 0), 32'h0);
        chk("a_pop1", log_at(pop_log, 1), 32'h4);
        chk("a_pop2", log_at(pop_log, 2), 32'h8);

        // Decode back-pressure fills the buffer, then drains in order
        do_reset();
        set_knobs(100, 0, 0, 1);
        run(12);
        chk("b_full_model", q_pc.size(), 2);
        chk("b_full_valid", out_inst_valid, 1);
        chk("b_full_head", out_inst_pc, 32'h0);
        chk("b_full_noreq", out_mem_req_valid, 0);
        set_knobs(100, 100, 0, 1);
        clear_logs();
        run(12);
        chk("b_pop0", log_at(pop_log, 0), 32'h0);
        chk("b_pop1", log_at(pop_log, 1), 32'h4);
        chk("b_pop2", log_at(pop_log, 2), 32'h8);
        chk("b_acc0", log_at(acc_log, 0), 32'h8);

        // Redirect while the 0x8 fetch is outstanding
        do_reset();
        set_knobs(100, 100, 0, 3);
        guard = 0;
        while (!(mem_busy && mem_addr == 32'h8) && guard < 60) begin run(1); guard++; end
        chk("c_reach_wait", guard < 60, 1);
        redirect_once(32'h100);
        chk("c_flushed", out_inst_valid, 0);
        clear_logs();
        run(20);
        chk("c_acc0", log_at(acc_log, 0), 32'h100);
        chk("c_pop0", log_at(pop_log, 0), 32'h100);

        // Memory stall at 0xC with a misaligned redirect mid-stall
        do_reset();
        set_knobs(100, 100, 0, 1);
        guard = 0;
        while (!(out_mem_req_valid && out_mem_req_addr == 32'hC) && guard < 60) begin run(1); guard++; end
        chk("d_reach_c", guard < 60, 1);
        set_knobs(0, 100, 0, 1);
        run(1);
        chk("d_hold_addr", out_mem_req_addr, 32'hC);
        redirect_once(32'h203);
        chk("d_redir_valid", out_mem_req_valid, 1);
        chk("d_redir_addr", out_mem_req_addr, 32'h200);
        run(1);
        set_knobs(100, 100, 0, 1);
        clear_logs();
        run(15);
        chk("d_acc0", log_at(acc_log, 0), 32'h200);
        chk("d_pop0", log_at(pop_log, 0), 32'h200);

        // PC wrap at the top of the address space
        redirect_once(32'hFFFF_FFFC);
        clear_logs();
        run(12);
        chk("e_acc0", log_at(acc_log, 0), 32'hFFFF_FFFC);
        chk("e_acc1", log_at(acc_log, 1), 32'h0);
        chk("e_pop0", log_at(pop_log, 0), 32'hFFFF_FFFC);
        chk("e_pop1", log_at(pop_log, 1), 32'h0);

        // Randomized traffic with redirects, stalls and variable latency
        for (int k = 0; k < 3; k++) begin
            do_reset();
            set_knobs(70, 60, 6, 3);
            run(1000);
        end
        set_knobs(100, 90, 15, 1);
        run(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
